// File: rtl/axis_test_pattern_source.sv
`default_nettype none
// ============================================================================
//  Module   : axis_test_pattern_source
//  Purpose  : AXI4-Stream video master producing IMG_WIDTH x IMG_HEIGHT
//             frames (h-ramp, v-ramp, checkerboard, impulse noise) with
//             tuser on pixel (0,0), tlast at end of line and full tready
//             backpressure support.
//  Revision : 1.0  initial release
// ============================================================================
module axis_test_pattern_source #(
   parameter int          DATA_WIDTH  = 8,
   parameter int          IMG_WIDTH   = 1280,
   parameter int          IMG_HEIGHT  = 1024,
   parameter int          H_BLANK     = 4,
   parameter int          CHECK_SHIFT = 3,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                  i_clk,
   input  logic                  i_aresetn,
   input  logic                  i_start,
   input  logic [1:0]            i_pattern_sel,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tuser,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  o_busy,
   output logic                  o_frame_done
);

   localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int BW = (H_BLANK > 0) ? $clog2(H_BLANK + 1) : 1;

   localparam logic [XW-1:0]         X_LAST     = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0]         Y_LAST     = YW'(IMG_HEIGHT - 1);
   localparam logic [BW-1:0]         BLANK_INIT = (H_BLANK > 0) ? BW'(H_BLANK - 1) : '0;
   localparam logic [DATA_WIDTH-1:0] PIX_MAX    = '1;
   localparam logic [DATA_WIDTH-1:0] PIX_MID    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_HBLANK = 2'd2
   } state_t;

   state_t                state_q,  state_d;
   logic [XW-1:0]         x_q,      x_d;
   logic [YW-1:0]         y_q,      y_d;
   logic [BW-1:0]         blank_q,  blank_d;
   logic [15:0]           lfsr_q,   lfsr_d;
   logic [1:0]            pat_q,    pat_d;
   logic [DATA_WIDTH-1:0] tdata_q,  tdata_d;
   logic                  tvalid_q, tvalid_d;
   logic                  tuser_q,  tuser_d;
   logic                  tlast_q,  tlast_d;
   logic                  busy_q,   busy_d;
   logic                  done_q,   done_d;

   logic [XW-1:0]         x_inc;
   logic [YW-1:0]         y_inc;
   logic [15:0]           lfsr_nxt;

   // Pixel value for a coordinate; the noise pattern only needs the LFSR low nibble.
   function automatic logic [DATA_WIDTH-1:0] pixel(
      input logic [1:0]    pat,
      input logic [XW-1:0] px,
      input logic [YW-1:0] py,
      input logic [3:0]    nib
   );
      logic chk_bit;
      chk_bit = 1'((px >> CHECK_SHIFT)) ^ 1'((py >> CHECK_SHIFT));
      case (pat)
         2'd0:    pixel = DATA_WIDTH'(px);
         2'd1:    pixel = DATA_WIDTH'(py);
         2'd2:    pixel = chk_bit ? PIX_MAX : '0;
         default: pixel = (nib == 4'd0) ? PIX_MAX :
                          (nib == 4'd1) ? '0 : PIX_MID;
      endcase
   endfunction

   // Fibonacci LFSR, taps 16/14/13/11, shifting towards the MSB.
   assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign x_inc    = x_q + XW'(1);
   assign y_inc    = y_q + YW'(1);

   // Next-state and next-output logic; every output is produced one cycle ahead.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      blank_d  = blank_q;
      lfsr_d   = lfsr_q;
      pat_d    = pat_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tuser_d  = tuser_q;
      tlast_d  = tlast_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // A start coinciding with the done pulse belongs to the finished frame.
            if (i_start && !done_q) begin
               state_d  = S_ACTIVE;
               pat_d    = i_pattern_sel;
               lfsr_d   = LFSR_SEED;
               x_d      = '0;
               y_d      = '0;
               tvalid_d = 1'b1;
               tuser_d  = 1'b1;
               tlast_d  = 1'b0;
               busy_d   = 1'b1;
               tdata_d  = pixel(i_pattern_sel, '0, '0, LFSR_SEED[3:0]);
            end
         end

         S_ACTIVE: begin
            if (tvalid_q && m_axis_tready) begin
               lfsr_d  = lfsr_nxt;
               tuser_d = 1'b0;
               if (x_q != X_LAST) begin
                  x_d     = x_inc;
                  tlast_d = (x_inc == X_LAST);
                  tdata_d = pixel(pat_q, x_inc, y_q, lfsr_nxt[3:0]);
               end else if (y_q == Y_LAST) begin
                  state_d  = S_IDLE;
                  x_d      = '0;
                  y_d      = '0;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  tdata_d  = '0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
               end else if (H_BLANK > 0) begin
                  state_d  = S_HBLANK;
                  x_d      = '0;
                  y_d      = y_inc;
                  blank_d  = BLANK_INIT;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  tdata_d  = '0;
               end else begin
                  x_d     = '0;
                  y_d     = y_inc;
                  tlast_d = 1'b0;
                  tdata_d = pixel(pat_q, '0, y_inc, lfsr_nxt[3:0]);
               end
            end
         end

         S_HBLANK: begin
            // x/y/lfsr already point at the first pixel of the next line.
            if (blank_q == '0) begin
               state_d  = S_ACTIVE;
               tvalid_d = 1'b1;
               tlast_d  = 1'b0;
               tdata_d  = pixel(pat_q, x_q, y_q, lfsr_q[3:0]);
            end else begin
               blank_d = blank_q - BW'(1);
            end
         end

         default: begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         blank_q  <= '0;
         lfsr_q   <= LFSR_SEED;
         pat_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tuser_q  <= 1'b0;
         tlast_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         blank_q  <= blank_d;
         lfsr_q   <= lfsr_d;
         pat_q    <= pat_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tuser_q  <= tuser_d;
         tlast_q  <= tlast_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tuser  = tuser_q;
   assign m_axis_tlast  = tlast_q;
   assign o_busy        = busy_q;
   assign o_frame_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_test_pattern_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_test_pattern_source
//  Purpose  : Self-checking bench for axis_test_pattern_source. Two instances:
//             A = 8x4 with 2 blank cycles, B = 16x16 back-to-back lines.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_test_pattern_source;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       tready;
   logic [1:0] sel;
   int         cur;

   logic [7:0] a_data, b_data, m_data;
   logic a_valid, a_user, a_last, a_busy, a_done;
   logic b_valid, b_user, b_last, b_busy, b_done;
   logic m_valid, m_user, m_last, m_busy, m_done;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] exp_data [0:255];
   logic       exp_user [0:255];
   logic       exp_last [0:255];
   logic [7:0] rx       [0:255];
   logic [7:0] rx_prev  [0:255];

   always #5 clk = ~clk;

   axis_test_pattern_source #(
      .DATA_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(4), .H_BLANK(2),
      .CHECK_SHIFT(3), .LFSR_SEED(16'hACE1)
   ) dut_a (
      .i_clk(clk), .i_aresetn(rst_n), .i_start(start && (cur == 0)),
      .i_pattern_sel(sel), .m_axis_tdata(a_data), .m_axis_tvalid(a_valid),
      .m_axis_tuser(a_user), .m_axis_tlast(a_last), .m_axis_tready(tready),
      .o_busy(a_busy), .o_frame_done(a_done)
   );

   axis_test_pattern_source #(
      .DATA_WIDTH(8), .IMG_WIDTH(16), .IMG_HEIGHT(16), .H_BLANK(0),
      .CHECK_SHIFT(3), .LFSR_SEED(16'hACE1)
   ) dut_b (
      .i_clk(clk), .i_aresetn(rst_n), .i_start(start && (cur == 1)),
      .i_pattern_sel(sel), .m_axis_tdata(b_data), .m_axis_tvalid(b_valid),
      .m_axis_tuser(b_user), .m_axis_tlast(b_last), .m_axis_tready(tready),
      .o_busy(b_busy), .o_frame_done(b_done)
   );

   assign m_data  = (cur == 1) ? b_data  : a_data;
   assign m_valid = (cur == 1) ? b_valid : a_valid;
   assign m_user  = (cur == 1) ? b_user  : a_user;
   assign m_last  = (cur == 1) ? b_last  : a_last;
   assign m_busy  = (cur == 1) ? b_busy  : a_busy;
   assign m_done  = (cur == 1) ? b_done  : a_done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Reference frame from the pattern definitions, one entry per beat in raster order.
   task automatic build_frame(input int pat, input int w, input int h);
      logic [15:0] s;
      int k;
      s = 16'hACE1;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            k = y * w + x;
            case (pat)
               0: exp_data[k] = 8'(x % 256);
               1: exp_data[k] = 8'(y % 256);
               2: exp_data[k] = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 8'd255 : 8'd0;
               default: exp_data[k] = (s[3:0] == 4'd0) ? 8'd255 :
                                      (s[3:0] == 4'd1) ? 8'd0 : 8'd128;
            endcase
            exp_user[k] = (k == 0);
            exp_last[k] = (x == w - 1);
            s = lfsr_step(s);
         end
      end
   endtask

   // Starts one frame and consumes it; abort_at >= 0 returns after that many beats.
   task automatic run_frame(input int pat, input int w, input int h, input int hb,
                            input bit rnd, input bit poke, input int abort_at);
      int total, idx, gap;
      bit line_end, prev_stall;
      logic [7:0] pd;
      logic pu, pl;
      build_frame(pat, w, h);
      total = w * h; idx = 0; gap = 0; line_end = 0; prev_stall = 0;
      pd = 0; pu = 0; pl = 0;
      @(negedge clk);
      sel = 2'(pat); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sel = ~2'(pat);
      chk("busy_after_start", 32'(m_busy), 1);
      for (int c = 0; c < 20000 && idx < total; c++) begin
         tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start  = (poke && idx >= 10 && idx < 12) ? 1'b1 : 1'b0;
         if (m_valid) begin
            if (prev_stall) begin
               chk("stall_data", 32'(m_data), 32'(pd));
               chk("stall_user", 32'(m_user), 32'(pu));
               chk("stall_last", 32'(m_last), 32'(pl));
            end
            if (line_end) begin
               chk("hblank_gap", 32'(gap), 32'(hb));
               line_end = 0;
            end
            gap = 0;
            if (tready) begin
               chk("tdata", 32'(m_data), 32'(exp_data[idx]));
               chk("tuser", 32'(m_user), 32'(exp_user[idx]));
               chk("tlast", 32'(m_last), 32'(exp_last[idx]));
               rx[idx] = m_data;
               if (exp_last[idx]) line_end = 1;
               idx++;
               prev_stall = 0;
            end else begin
               prev_stall = 1;
               pd = m_data; pu = m_user; pl = m_last;
            end
         end else begin
            if (prev_stall) chk("valid_held", 32'(m_valid), 1);
            prev_stall = 0;
            gap++;
         end
         if (abort_at >= 0 && idx == abort_at) return;
         @(negedge clk);
      end
      start = 1'b0;
      chk("beat_count", 32'(idx), 32'(total));
      chk("done_pulse", 32'(m_done), 1);
      chk("busy_at_done", 32'(m_busy), 0);
      chk("valid_at_done", 32'(m_valid), 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", 32'(m_done), 0);
      chk("start_at_done_ignored", 32'(m_busy), 0);
      chk("no_valid_after_done", 32'(m_valid), 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; tready = 1'b0; sel = 2'd0; cur = 0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(a_valid), 0);
      chk("rst_data",  32'(a_data), 0);
      chk("rst_busy",  32'(a_busy), 0);
      chk("rst_done",  32'(a_done), 0);
      rst_n = 1'b1;

      // h-ramp, full rate, with a start pulse injected mid-frame
      run_frame(0, 8, 4, 2, 1'b0, 1'b1, -1);
      // h-ramp under random backpressure
      run_frame(0, 8, 4, 2, 1'b1, 1'b0, -1);

      // v-ramp and checker on the back-to-back 16x16 instance
      cur = 1;
      run_frame(1, 16, 16, 0, 1'b0, 1'b0, -1);
      run_frame(2, 16, 16, 0, 1'b1, 1'b0, -1);
      chk("chk_0_0", 32'(rx[0]), 0);
      chk("chk_8_0", 32'(rx[8]), 255);
      chk("chk_0_8", 32'(rx[8 * 16]), 255);
      chk("chk_8_8", 32'(rx[8 * 16 + 8]), 0);
      chk("chk_7_7", 32'(rx[7 * 16 + 7]), 0);

      // noise, two frames must repeat exactly
      cur = 0;
      run_frame(3, 8, 4, 2, 1'b1, 1'b0, -1);
      for (int i = 0; i < 32; i++) rx_prev[i] = rx[i];
      run_frame(3, 8, 4, 2, 1'b0, 1'b0, -1);
      for (int i = 0; i < 32; i++) begin
         chk("noise_repeat", 32'(rx[i]), 32'(rx_prev[i]));
         chk("noise_legal", 32'((rx[i] == 8'd0) || (rx[i] == 8'd128) || (rx[i] == 8'd255)), 1);
      end

      // reset mid-frame, then a fresh frame
      run_frame(0, 8, 4, 2, 1'b0, 1'b0, 10);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(a_valid), 0);
      chk("midrst_user",  32'(a_user), 0);
      chk("midrst_last",  32'(a_last), 0);
      chk("midrst_data",  32'(a_data), 0);
      chk("midrst_busy",  32'(a_busy), 0);
      chk("midrst_done",  32'(a_done), 0);
      repeat (2) @(negedge clk);
      chk("midrst_hold_valid", 32'(a_valid), 0);
      rst_n = 1'b1;
      run_frame(0, 8, 4, 2, 1'b0, 1'b0, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
